// File: rtl/axi_slave_mem.sv
// AXI3 burst slave memory: FIXED/INCR/WRAP, byte strobes, ID echo.
// Define AXI_SLAVE_MEM_RANGE_CHECK_EN for per-beat out-of-range SLVERR.
module axi_slave_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_DEPTH  = 128
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [3:0]              awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [ID_WIDTH-1:0]     wid,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ID_WIDTH-1:0]     arid,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [3:0]              arlen,
    input  logic [2:0]              arsize,
    input  logic [1:0]              arburst,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [ID_WIDTH-1:0]     rid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFFB  = $clog2(BYTES);
    localparam int IDXW  = $clog2(MEM_DEPTH);
    localparam logic [1:0] RESP_OK  = 2'b00;
    localparam logic [1:0] RESP_ERR = 2'b10;
`ifdef AXI_SLAVE_MEM_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
    typedef enum logic {R_IDLE, R_DATA} rstate_e;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    function automatic logic [2:0] clamp_size(input logic [2:0] s);
        return (s > 3'(OFFB)) ? 3'(OFFB) : s;
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] next_addr(
        input logic [ADDR_WIDTH-1:0] a,
        input logic [3:0]            len,
        input logic [2:0]            size,
        input logic [1:0]            burst
    );
        logic [ADDR_WIDTH-1:0] inc;
        logic [ADDR_WIDTH-1:0] mask;
        inc  = ADDR_WIDTH'(1) << size;
        mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
        case (burst)
            2'd0:    next_addr = a;
            2'd2:    next_addr = (a & ~mask) | ((a + inc) & mask);
            default: next_addr = a + inc;
        endcase
    endfunction

    function automatic logic [IDXW-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
        return a[OFFB +: IDXW];
    endfunction

    function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] a);
        return RANGE_EN && ((a >> (OFFB + IDXW)) != '0);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] rd_word(input logic [ADDR_WIDTH-1:0] a);
        return out_of_range(a) ? '0 : mem[word_idx(a)];
    endfunction

    logic unused_wid;
    assign unused_wid = ^wid;

    // Holds both address channels off until the first edge after reset.
    logic rst_done_q;
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) rst_done_q <= 1'b0;
        else          rst_done_q <= 1'b1;
    end

    wstate_e               wstate_q, wstate_d;
    logic [ID_WIDTH-1:0]   awid_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [3:0]            wlen_q, wcnt_q;
    logic [2:0]            wsize_q;
    logic [1:0]            wburst_q;
    logic                  werr_q;
    logic                  aw_hs, w_hs, w_final, w_oor, mem_we;

    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;
    assign w_final = (wcnt_q == wlen_q);
    assign w_oor   = out_of_range(waddr_q);
    assign mem_we  = w_hs && !w_oor;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) wstate_q <= W_IDLE;
        else          wstate_q <= wstate_d;
    end

    always_comb begin
        wstate_d = wstate_q;
        unique case (wstate_q)
            W_IDLE:  if (aw_hs) wstate_d = W_DATA;
            W_DATA:  if (w_hs && w_final) wstate_d = W_RESP;
            W_RESP:  if (bvalid && bready) wstate_d = W_IDLE;
            default: wstate_d = W_IDLE;
        endcase
    end

    always_comb begin
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        unique case (wstate_q)
            W_IDLE:  awready = rst_done_q;
            W_DATA:  wready  = 1'b1;
            W_RESP:  bvalid  = 1'b1;
            default: ;
        endcase
    end

    // The beat counter decides the end of burst; wlast only flags errors.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            awid_q   <= '0;
            waddr_q  <= '0;
            wlen_q   <= '0;
            wsize_q  <= '0;
            wburst_q <= '0;
            wcnt_q   <= '0;
            werr_q   <= 1'b0;
        end else if (aw_hs) begin
            awid_q   <= awid;
            waddr_q  <= awaddr;
            wlen_q   <= awlen;
            wsize_q  <= clamp_size(awsize);
            wburst_q <= awburst;
            wcnt_q   <= '0;
            werr_q   <= 1'b0;
        end else if (w_hs) begin
            waddr_q <= next_addr(waddr_q, wlen_q, wsize_q, wburst_q);
            wcnt_q  <= wcnt_q + 4'd1;
            werr_q  <= werr_q | w_oor | (wlast != w_final);
        end
    end

    assign bid   = awid_q;
    assign bresp = werr_q ? RESP_ERR : RESP_OK;

    always_ff @(posedge aclk) begin
        if (mem_we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (wstrb[b]) mem[word_idx(waddr_q)][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    rstate_e               rstate_q, rstate_d;
    logic [ID_WIDTH-1:0]   rid_q;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_nx;
    logic [3:0]            rlen_q, rcnt_q;
    logic [2:0]            rsize_q;
    logic [1:0]            rburst_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;
    logic                  ar_hs, r_hs, r_final;

    assign ar_hs    = arvalid && arready;
    assign r_hs     = rvalid && rready;
    assign r_final  = (rcnt_q == rlen_q);
    assign raddr_nx = next_addr(raddr_q, rlen_q, rsize_q, rburst_q);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) rstate_q <= R_IDLE;
        else          rstate_q <= rstate_d;
    end

    always_comb begin
        rstate_d = rstate_q;
        unique case (rstate_q)
            R_IDLE:  if (ar_hs) rstate_d = R_DATA;
            R_DATA:  if (r_hs && r_final) rstate_d = R_IDLE;
            default: rstate_d = R_IDLE;
        endcase
    end

    always_comb begin
        arready = 1'b0;
        rvalid  = 1'b0;
        rlast   = 1'b0;
        unique case (rstate_q)
            R_IDLE:  arready = rst_done_q;
            R_DATA: begin
                rvalid = 1'b1;
                rlast  = r_final;
            end
            default: ;
        endcase
    end

    // rdata is registered from the array, so a same-edge write is not seen.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rid_q    <= '0;
            raddr_q  <= '0;
            rlen_q   <= '0;
            rsize_q  <= '0;
            rburst_q <= '0;
            rcnt_q   <= '0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OK;
        end else if (ar_hs) begin
            rid_q    <= arid;
            raddr_q  <= araddr;
            rlen_q   <= arlen;
            rsize_q  <= clamp_size(arsize);
            rburst_q <= arburst;
            rcnt_q   <= '0;
            rdata_q  <= rd_word(araddr);
            rresp_q  <= out_of_range(araddr) ? RESP_ERR : RESP_OK;
        end else if (r_hs && !r_final) begin
            raddr_q <= raddr_nx;
            rcnt_q  <= rcnt_q + 4'd1;
            rdata_q <= rd_word(raddr_nx);
            rresp_q <= out_of_range(raddr_nx) ? RESP_ERR : RESP_OK;
        end
    end

    assign rid   = rid_q;
    assign rdata = rdata_q;
    assign rresp = rresp_q;

endmodule

// File: doc/axi_slave_mem.md
# axi_slave_mem

Parametrised AXI3 slave memory model for the BFM test environment. It is the burst-capable successor to the generic slave: it supports configurable data, address and ID widths and memory depth. It implements full valid/ready handshakes on all five channels, with FIXED/INCR/WRAP bursts, byte strobes, ID echo and correct `rlast`/`bresp`. Testbenches instantiate it as the target behind AXI master BFMs.

## Interface
- `DATA_WIDTH`, 32: data bus width in bits (32 or 64).
- `ADDR_WIDTH`, 32: byte address width.
- `ID_WIDTH`, 4: transaction ID width.
- `MEM_DEPTH`, 128: number of `DATA_WIDTH` words (power of two).
- `aclk` in 1: clock; all logic on rising edge.
- `aresetn` in 1: reset, asynchronous, active-low.
- `awid`/`awaddr`/`awlen`/`awsize`/`awburst` in ID_WIDTH/ADDR_WIDTH/4/3/2: write address payload.
- `awvalid` in 1, `awready` out 1: write address handshake.
- `wid`/`wdata`/`wstrb`/`wlast` in ID_WIDTH/DATA_WIDTH/DATA_WIDTH/8/1: write data payload (`wid` ignored).
- `wvalid` in 1, `wready` out 1: write data handshake.
- `bid`/`bresp` out ID_WIDTH/2: write response payload.
- `bvalid` out 1, `bready` in 1: write response handshake.
- `arid`/`araddr`/`arlen`/`arsize`/`arburst` in ID_WIDTH/ADDR_WIDTH/4/3/2: read address payload.
- `arvalid` in 1, `arready` out 1: read address handshake.
- `rid`/`rdata`/`rresp`/`rlast` out ID_WIDTH/DATA_WIDTH/2/1: read data payload.
- `rvalid` out 1, `rready` in 1: read data handshake.

## Operation
- The write and read FSMs are independent; one transaction is outstanding per direction.
- Write FSM states: W_IDLE (`awready`=1), W_DATA (`wready`=1), W_RESP (`bvalid`=1).
  - W_IDLE→W_DATA on AW handshake: capture id, addr, len, size, burst; clear beat count.
  - In W_DATA, each W handshake writes the strobed bytes of `wdata` at that edge. The beat count is authoritative: the beat where count==len moves to W_RESP.
  - `wlast` mismatch (asserted early, or missing on the final beat): `bresp`=SLVERR (2'b10), otherwise OKAY.
  - W_RESP→W_IDLE on `bvalid && bready`.
- Read FSM states: R_IDLE (`arready`=1), R_DATA (`rvalid`=1).
  - AR handshake captures the payload and loads beat 0 into `rdata`.
  - Each R handshake loads the next beat. `rlast`=1 when count==len. R_DATA→R_IDLE on the last-beat handshake.
- Address sequencing:
  - Beat address increment = 1<<size. `size` is clamped to log2(DATA_WIDTH/8).
  - FIXED (0): constant. INCR (1): increments. WRAP (2): wraps within an aligned (len+1)<<size byte window. Reserved (3): treated as INCR.
  - Word index = addr[ADDR_WIDTH-1:log2(DATA_WIDTH/8)] modulo MEM_DEPTH.
- Same-cycle read and write to one word: read returns the pre-write data.
- Memory contents are not reset.

## Timing
- Reset values: `awready`, `wready`, `bvalid`, `arready`, `rvalid`, `rlast` = 0; `bid`, `rid`, `rdata` = 0; `bresp`, `rresp` = OKAY.
- `awready`/`arready` rise at the first clock edge after `aresetn` deasserts.
- AW handshake → `wready` next cycle. Final W beat → `bvalid` next cycle.
- AR handshake → first `rvalid` next cycle; latency 1.
- Beats stream back-to-back while `rready` is held. Zero bubbles on W while `wvalid` is held.
- `rdata`/`rid`/`rresp`/`rlast` are held stable while `rvalid && !rready`. `bid`/`bresp` are held while `bvalid && !bready`.
- Reset asserted mid-burst: outputs go to reset values immediately and the transaction is dropped with no response. Beats already written stay in memory.

## Configuration
- `AXI_SLAVE_MEM_RANGE_CHECK_EN` defined:
  - A burst beat whose word index is ≥ MEM_DEPTH is not written and gives `bresp`=SLVERR.
  - Such a read beat returns `rdata`=0 with `rresp`=SLVERR.
  - The check is per beat on the unwrapped index.
- Undefined: no check is done; addresses alias modulo MEM_DEPTH and responses are always OKAY unless there is a `wlast` mismatch.

## Test plan
- Single write 0x10 = 0xDEADBEEF, strb 4'hF, then read 0x10, len 0 → `bvalid` one cycle with `bid`=`awid`, OKAY; `rdata`=0xDEADBEEF, `rlast`=1, `rid`=`arid`.
- INCR len 3 at 0x20, data 1,2,3,4; read back with `rready` toggling every cycle → 1,2,3,4 in order, `rlast` only on beat 4, `rdata` stable during stalls.
- WRAP len 3 size 2 at 0x38, data A,B,C,D → words 0x38=A, 0x3C=B, 0x30=C, 0x34=D.
- Word preloaded 0xFFFFFFFF, write 0x11223344 with strb 4'b0101 → read 0xFF22FF44.
- len 3 write with `wlast` on beat 2 → four beats accepted, `bresp`=2'b10. Then read 0x400 with MEM_DEPTH 128 → macro defined: SLVERR and `rdata` 0; macro undefined: data of 0x000.
- `aresetn` pulsed low during beat 2 of a len 7 read → `rvalid` low immediately, `arready`=1 one edge after release, and a new read completes normally.
